// File: rtl/fifo_pop_stager.sv
// Pop-side staging buffer for the dual-read show-ahead FIFO: issues up to two
// pops per cycle into a registered 2-entry buffer and streams words out in order.
module fifo_pop_stager #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic              almost_empty,
    input  logic [DWIDTH-1:0] pop_data0,
    input  logic [DWIDTH-1:0] pop_data1,
    output logic              pop0,
    output logic              pop1,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic              idle,
    output logic [CNT_W-1:0]  pop_count
);

    logic [1:0]        occ_q, occ_d;
    logic [DWIDTH-1:0] buf0_q, buf0_d;
    logic [DWIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       drain;
    logic [1:0] avail;
    logic [1:0] free;
    logic [1:0] n;
    logic [1:0] rem;

    // Pop decision; out_ready feeds pop0/pop1 combinationally so a draining
    // full buffer can refill in the same cycle.
    always_comb begin
        drain = (occ_q != 2'd0) & out_ready;
        if (empty)             avail = 2'd0;
        else if (almost_empty) avail = 2'd1;
        else                   avail = 2'd2;
        free = 2'd2 - occ_q + {1'b0, drain};
        if (rst || flush)      n = 2'd0;
        else if (free < avail) n = free;
        else                   n = avail;
        rem = occ_q - {1'b0, drain};
    end

    assign pop0 = (n != 2'd0);
    assign pop1 = (n == 2'd2);

    // Shift out the delivered head first, then append popped words behind
    // whatever is still staged.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (drain) buf0_d = buf1_q;
        case (rem)
            2'd0: begin
                if (n >= 2'd1) buf0_d = pop_data0;
                if (n == 2'd2) buf1_d = pop_data1;
            end
            2'd1: begin
                if (n >= 2'd1) buf1_d = pop_data0;
            end
            default: ;
        endcase
        occ_d = flush ? 2'd0 : (rem + n);
        cnt_d = cnt_q + CNT_W'(n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;
    assign idle      = (occ_q == 2'd0) & empty;
    assign pop_count = cnt_q;

endmodule

// File: doc/fifo_pop_stager.md
# fifo_pop_stager

Pop-side staging stage that sits directly downstream of the dual-read FIFO in the RVV datapath. It issues `pop0`/`pop1` against the FIFO's two show-ahead read ports and holds up to two popped words in a registered 2-entry buffer. It presents them in order, one per cycle, on a single valid/ready stream to the consumer. It also reports idle status and a running pop count for the FIFO testbench scoreboard.

## Interface
Parameters:
- `DWIDTH`, 32: data word width.
- `CNT_W`, 16: width of `pop_count`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `empty`  in  1  FIFO holds 0 entries.
- `almost_empty`  in  1  FIFO holds ≤1 entry.
- `pop_data0`  in  DWIDTH  FIFO head word (show-ahead); valid when `!empty`.
- `pop_data1`  in  DWIDTH  FIFO head+1 word; valid when `!almost_empty`.
- `pop0`  out  1  pop head this cycle.
- `pop1`  out  1  pop head+1 this cycle; only asserted together with `pop0`.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_data`  out  DWIDTH  oldest staged word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `flush`  in  1  discard staged words.
- `idle`  out  1  buffer empty and FIFO empty.
- `pop_count`  out  CNT_W  total words popped since reset; wraps.

## Operation
- State:
  - `occ` ∈ {0,1,2}.
  - `buf0` is the head and drives `out_data`; `buf1` is second.
  - `out_valid = (occ != 0)`.
- Per cycle:
  - `drain = out_valid & out_ready`.
  - `avail = empty ? 0 : almost_empty ? 1 : 2`.
  - `free = 2 - occ + drain`.
  - `n = flush ? 0 : min(free, avail)`.
- Pops: `pop0 = (n >= 1)`, `pop1 = (n == 2)`. This is combinational from `occ`, `out_ready`, `flush`, `empty`, `almost_empty`. The `out_ready`→`pop*` path is intentional.
- Buffer update, oldest first:
  - Remove `buf0` if `drain`, shifting `buf1` into `buf0`.
  - Then append `pop_data0`, then `pop_data1`, for each pop issued.
  - `occ_next = occ - drain + n`, never exceeding 2.
- Flush:
  - A transfer completing in the flush cycle (`drain`) counts as delivered.
  - All remaining staged words are discarded, `occ_next = 0`, and no pops are issued that cycle.
  - Words still in the FIFO are untouched.
- `pop_count += n` each cycle, modulo 2^CNT_W. `flush` does not clear it.
- `idle = (occ == 0) & empty`.
- Reset (`rst` high at a clock edge):
  - `occ = 0`, `buf0 = buf1 = 0`, `pop_count = 0`.
  - While `rst` is high, `pop0`/`pop1` are forced 0. Reset takes priority over `flush` and handshakes.

## Timing
- Outputs after reset: `out_valid` 0, `out_data` 0, `pop0`/`pop1` 0, `idle` = `empty`, `pop_count` 0.
- Latency: a word popped in cycle t appears on `out_data` with `out_valid` at t+1 if it is the oldest staged word.
- Throughput: 1 word/cycle sustained with `out_ready` held high. Up to 2 words are prefetched per cycle when the buffer is empty.
- `out_data` and `out_valid` are registered, with no combinational path from the FIFO inputs.
- Valid/ready rules:
  - Once `out_valid` is high it stays high, with `out_data` stable, until `drain` or `flush`.
  - `out_ready` may be asserted while `out_valid` is low; it has no effect then.
- Boundaries:
  - Full buffer (`occ=2`) with `out_ready=0`: `pop0=pop1=0`.
  - `occ=2` with `drain`: exactly one pop if the FIFO is non-empty.
  - FIFO holds exactly 1 entry (`almost_empty=1`, `empty=0`): only `pop0` is ever issued.
  - Consumer stall mid-burst: no pops are lost and no word is duplicated.
  - `pop_count` wraps from 2^CNT_W-1 to 0.

## Test plan
- Reset, then the FIFO is preloaded with A,B,C and `out_ready` is held 1.
  - Cycle 0: `pop0=pop1=1`. Cycle 1: `out_data=A`, one pop (C).
  - `out_data` shows A, B, C on consecutive cycles, then `out_valid=0`, `idle=1`, `pop_count=3`.
- The FIFO holds 5 words and `out_ready` is held 0.
  - After 1 cycle, `occ=2` and no further pops.
  - When `out_ready` rises for one cycle, exactly one `pop0` occurs and order is preserved.
- The FIFO holds 1 word: `pop0=1`, `pop1=0`. Next cycle `out_valid=1`, and `almost_empty` never triggers `pop1`.
- `occ=2` with words X,Y; assert `flush` with `out_ready=1`.
  - X counts as delivered, Y is discarded, no pops occur that cycle.
  - Next cycle `out_valid=0`, then the next FIFO word is fetched normally.
- Assert `rst` mid-stream with `occ=2`.
  - Next cycle: `out_valid=0`, `out_data=0`, `pop_count=0`.
  - No pops while `rst` is high.
- With CNT_W=4, pop 17 words: `pop_count=1`. Randomized `out_ready` with a scoreboard shows in-order, loss-free delivery.
